// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants common to the transmitter and the existing receiver,
// plus the transmitter state encoding.
package uart_pkg;

  localparam int unsigned DATA_BITS    = 8;
  localparam int unsigned CLKS_PER_BIT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit byte buffer: first-word-fall-through FIFO with an explicit occupancy counter.
// Pushes while full and pops while empty are ignored.
module uart_tx_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] din,
  input  logic             pop,
  output logic [Width-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CntFull);
  assign empty   = (count_q == '0);
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap naturally because Depth is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: buffered 8N1 framing. The line output is registered from the current state,
// so tx trails the FSM by one cycle while every bit is still held CLKS_PER_BIT cycles.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       send,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  import uart_pkg::*;

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] IdxLast = 3'(DATA_BITS - 1);

  tx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;

  logic       fifo_push, fifo_pop;
  logic       fifo_full, fifo_empty;
  logic [7:0] fifo_dout;
  logic       cnt_wrap;

  assign ready     = ~fifo_full;
  assign fifo_push = send & ready;
  assign cnt_wrap  = (cnt_q == CntMax);
  assign busy      = (state_q != IDLE) | ~fifo_empty;
  assign tx        = tx_q;

  uart_tx_fifo #(
    .Depth(FIFO_DEPTH),
    .Width(DATA_BITS)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (fifo_push),
    .din  (data),
    .pop  (fifo_pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    if (state_q != IDLE) begin
      cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          state_d  = START;
        end
      end
      START: begin
        if (cnt_wrap) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (cnt_wrap) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == IdxLast) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        // Chain straight into the next frame when a byte is waiting.
        if (cnt_wrap) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a frame-level line model (byte queue + frame countdown) checked every cycle,
// and an independent mid-bit sampling receiver whose decoded bytes are compared per scenario.
module tb_uart_tx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       send  = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       ready, tx, busy;

  uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .data (data),
    .send (send),
    .ready(ready),
    .tx   (tx),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model state
  logic [7:0] m_q[$];
  logic [7:0] exp_q[$];
  bit         m_active = 1'b0;
  int         m_rem    = 0;
  logic [7:0] m_byte   = 8'h00;
  logic       m_line   = 1'b1;
  logic       m_tx     = 1'b1;
  logic       m_busy   = 1'b0;
  logic       m_ready  = 1'b1;
  int         m_epoch  = 0;

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  // One rising edge of the model; the line value shows up on tx one edge later.
  task automatic model_edge();
    int pre;
    pre = m_q.size();
    if (reset) begin
      m_q.delete();
      m_active = 1'b0;
      m_rem    = 0;
      m_line   = 1'b1;
      m_tx     = 1'b1;
      m_epoch++;
    end else begin
      m_tx = m_line;
      if (m_active) begin
        m_rem--;
        if (m_rem == 0) begin
          exp_q.push_back(m_byte);
          m_active = 1'b0;
        end
      end
      if (!m_active && m_q.size() > 0) begin
        m_byte   = m_q.pop_front();
        m_active = 1'b1;
        m_rem    = FRAME;
      end
      if (send && pre < DEPTH) m_q.push_back(data);
      m_line = m_active ? frame_bit(m_byte, (FRAME - m_rem) / CPB) : 1'b1;
    end
    m_busy  = m_active || (m_q.size() != 0);
    m_ready = (m_q.size() < DEPTH);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
  endtask

  // Independent receiver: start on a low sample, then sample each bit at its middle.
  logic [8:0] rx_q[$];
  int         dec_cnt   = -1;
  int         dec_epoch = 0;
  logic [7:0] dec_sh    = 8'h00;

  always @(negedge clk) begin
    if (dec_epoch != m_epoch) begin
      dec_epoch <= m_epoch;
      dec_cnt   <= -1;
    end else if (dec_cnt < 0) begin
      if (tx === 1'b0) dec_cnt <= 1;
    end else begin
      if (dec_cnt % CPB == CPB / 2 && dec_cnt > CPB && dec_cnt < 9 * CPB)
        dec_sh[dec_cnt / CPB - 1] <= tx;
      if (dec_cnt == 9 * CPB + CPB / 2) begin
        rx_q.push_back({~tx, dec_sh});
        dec_cnt <= -1;
      end else begin
        dec_cnt <= dec_cnt + 1;
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    send  = 1'b1;
    data  = 8'hFF;
    step();
    step();
    n_cmp++;
    if ({tx, busy, ready} !== 3'b101) begin
      n_fail++;
      $display("FAIL reset_state tx/busy/ready got %b%b%b want 101", tx, busy, ready);
    end
    reset = 1'b0;
    send  = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      n_cmp++;
      if ({tx, busy, ready} !== {m_tx, m_busy, m_ready}) begin
        n_fail++;
        $display("FAIL reset_line cyc %0d tx/busy/ready got %b%b%b want %b%b%b",
                 cyc, tx, busy, ready, m_tx, m_busy, m_ready);
      end
    end
    n_cmp++;
    if (rx_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_send_ignored frames got %0d want 0", rx_q.size());
    end
  endtask

  task automatic test_single_byte();
    int t_low = -1;
    int t_busy = -1;
    rx_q.delete();
    exp_q.delete();
    data = 8'hA5;
    send = 1'b1;
    step();
    send = 1'b0;
    for (int i = 1; i <= FRAME + 40; i++) begin
      data = 8'($urandom);
      step();
      n_cmp++;
      if ({tx, busy, ready} !== {m_tx, m_busy, m_ready}) begin
        n_fail++;
        $display("FAIL single_line cyc %0d tx/busy/ready got %b%b%b want %b%b%b",
                 cyc, tx, busy, ready, m_tx, m_busy, m_ready);
      end
      if (t_low < 0 && tx === 1'b0) t_low = i;
      if (t_busy < 0 && busy === 1'b0) t_busy = i;
    end
    n_cmp++;
    if (t_low != 2) begin
      n_fail++;
      $display("FAIL single_latency start edge got E+%0d want E+2", t_low);
    end
    n_cmp++;
    if (t_busy != FRAME + 1) begin
      n_fail++;
      $display("FAIL single_busy_fall edge got E+%0d want E+%0d", t_busy, FRAME + 1);
    end
    n_cmp++;
    if (rx_q.size() != 1 || rx_q[0] !== 9'h0A5) begin
      n_fail++;
      $display("FAIL single_decode got %0d frames first %h want 1 frame 0a5",
               rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 9'h1FF);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals[3] = '{8'h00, 8'hFF, 8'h55};
    int e0;
    int t_busy = -1;
    rx_q.delete();
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      data = vals[k];
      send = 1'b1;
      step();
      if (k == 0) e0 = cyc;
    end
    send = 1'b0;
    for (int i = 0; i < 3 * FRAME + 40; i++) begin
      data = 8'($urandom);
      step();
      n_cmp++;
      if ({tx, busy, ready} !== {m_tx, m_busy, m_ready}) begin
        n_fail++;
        $display("FAIL b2b_line cyc %0d tx/busy/ready got %b%b%b want %b%b%b",
                 cyc, tx, busy, ready, m_tx, m_busy, m_ready);
      end
      if (t_busy < 0 && busy === 1'b0) t_busy = cyc - e0;
    end
    n_cmp++;
    if (t_busy != 3 * FRAME + 1) begin
      n_fail++;
      $display("FAIL b2b_busy_fall edge got E+%0d want E+%0d", t_busy, 3 * FRAME + 1);
    end
    n_cmp++;
    if (rx_q.size() != 3) begin
      n_fail++;
      $display("FAIL b2b_count frames got %0d want 3", rx_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (rx_q[k] !== {1'b0, vals[k]}) begin
          n_fail++;
          $display("FAIL b2b_byte%0d got %h want %h", k, rx_q[k], {1'b0, vals[k]});
        end
      end
    end
  endtask

  task automatic test_full();
    logic [7:0] b[6];
    for (int k = 0; k < 6; k++) b[k] = 8'($urandom);
    b[5] = b[4] ^ 8'h5A;
    rx_q.delete();
    exp_q.delete();
    data = b[0];
    send = 1'b1;
    step();
    send = 1'b0;
    for (int i = 0; i < 20; i++) step();
    for (int k = 1; k < 6; k++) begin
      data = b[k];
      send = 1'b1;
      step();
      n_cmp++;
      if ({tx, busy, ready} !== {m_tx, m_busy, m_ready}) begin
        n_fail++;
        $display("FAIL full_line cyc %0d tx/busy/ready got %b%b%b want %b%b%b",
                 cyc, tx, busy, ready, m_tx, m_busy, m_ready);
      end
      if (k >= 4) begin
        n_cmp++;
        if (ready !== 1'b0) begin
          n_fail++;
          $display("FAIL full_ready after push %0d got %b want 0", k, ready);
        end
      end
    end
    send = 1'b0;
    for (int i = 0; i < 5 * FRAME + 40; i++) begin
      data = 8'($urandom);
      step();
      n_cmp++;
      if ({tx, busy, ready} !== {m_tx, m_busy, m_ready}) begin
        n_fail++;
        $display("FAIL full_line cyc %0d tx/busy/ready got %b%b%b want %b%b%b",
                 cyc, tx, busy, ready, m_tx, m_busy, m_ready);
      end
    end
    n_cmp++;
    if (rx_q.size() != 5) begin
      n_fail++;
      $display("FAIL full_count frames got %0d want 5", rx_q.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_cmp++;
        if (rx_q[k] !== {1'b0, b[k]}) begin
          n_fail++;
          $display("FAIL full_byte%0d got %h want %h", k, rx_q[k], {1'b0, b[k]});
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    rx_q.delete();
    exp_q.delete();
    data = 8'h3C;
    send = 1'b1;
    step();
    data = 8'hC3;
    step();
    data = 8'h81;
    step();
    send = 1'b0;
    // Start state was entered one edge after the write; reset lands 40 cycles into it.
    for (int i = 3; i < 41; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++;
    if ({tx, busy, ready} !== 3'b101) begin
      n_fail++;
      $display("FAIL abort_state tx/busy/ready got %b%b%b want 101", tx, busy, ready);
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      n_cmp++;
      if ({tx, busy, ready} !== {m_tx, m_busy, m_ready}) begin
        n_fail++;
        $display("FAIL abort_line cyc %0d tx/busy/ready got %b%b%b want %b%b%b",
                 cyc, tx, busy, ready, m_tx, m_busy, m_ready);
      end
    end
    n_cmp++;
    if (rx_q.size() != 0) begin
      n_fail++;
      $display("FAIL abort_frames got %0d want 0", rx_q.size());
    end
  endtask

  task automatic test_loopback();
    int nxt = 0;
    int idle_run = 0;
    rx_q.delete();
    exp_q.delete();
    for (int g = 0; g < 50000 && idle_run < 20; g++) begin
      send = 1'b0;
      data = 8'($urandom);
      if (nxt < 256 && m_ready && $urandom_range(0, 3) == 0) begin
        send = 1'b1;
        data = 8'(nxt);
        nxt++;
      end
      step();
      n_cmp++;
      if ({tx, busy, ready} !== {m_tx, m_busy, m_ready}) begin
        n_fail++;
        $display("FAIL loop_line cyc %0d tx/busy/ready got %b%b%b want %b%b%b",
                 cyc, tx, busy, ready, m_tx, m_busy, m_ready);
      end
      idle_run = (nxt == 256 && !m_busy) ? idle_run + 1 : 0;
    end
    send = 1'b0;
    n_cmp++;
    if (rx_q.size() != 256) begin
      n_fail++;
      $display("FAIL loop_count frames got %0d want 256", rx_q.size());
    end else begin
      for (int k = 0; k < 256; k++) begin
        n_cmp++;
        if (rx_q[k] !== {1'b0, 8'(k)}) begin
          n_fail++;
          $display("FAIL loop_byte%0d got %h want %h", k, rx_q[k], {1'b0, 8'(k)});
        end
      end
    end
  endtask

  task automatic test_random();
    int idle_run = 0;
    rx_q.delete();
    exp_q.delete();
    for (int g = 0; g < 20000 && (g < 400 || idle_run < 20); g++) begin
      send = (g < 400) && ($urandom_range(0, 5) == 0);
      data = 8'($urandom);
      step();
      n_cmp++;
      if ({tx, busy, ready} !== {m_tx, m_busy, m_ready}) begin
        n_fail++;
        $display("FAIL rand_line cyc %0d tx/busy/ready got %b%b%b want %b%b%b",
                 cyc, tx, busy, ready, m_tx, m_busy, m_ready);
      end
      idle_run = (g >= 400 && !m_busy) ? idle_run + 1 : 0;
    end
    send = 1'b0;
    n_cmp++;
    if (rx_q.size() != exp_q.size() || exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL rand_count frames got %0d want %0d", rx_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[k]) begin
        n_cmp++;
        if (rx_q[k] !== {1'b0, exp_q[k]}) begin
          n_fail++;
          $display("FAIL rand_byte%0d got %h want %h", k, rx_q[k], {1'b0, exp_q[k]});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_full();
    test_reset_mid_frame();
    test_random();
    test_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; the value SHALL be at least 2.
REQ-002 Parameter FIFO_DEPTH, default 4, transmit buffer entries; the value SHALL be a power of two and at least 2.
REQ-003 clk  input  1  clock; all logic SHALL be clocked on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 data  input  8  byte to transmit; SHALL be sampled only when a write is accepted.
REQ-006 send  input  1  write request.
REQ-007 ready  output  1  buffer can accept a byte; SHALL be high when the FIFO is not full.
REQ-008 tx  output  1  serial line, idle high; SHALL be driven from a flop.
REQ-009 busy  output  1  high while a frame is on the line or the FIFO is non-empty.

Function
REQ-010 A write SHALL be accepted on a rising edge where send=1 and ready=1; send while ready=0 SHALL be ignored with no state change.
REQ-011 Frame format SHALL be: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each held exactly CLKS_PER_BIT cycles, for a frame length of 10*CLKS_PER_BIT cycles.
REQ-012 The FSM SHALL have exactly four states:
- IDLE: tx=1.
- START: tx=0.
- DATA: tx=shift[0].
- STOP: tx=1.
REQ-013 A bit counter (width clog2(CLKS_PER_BIT)) SHALL advance each cycle outside IDLE and wrap at CLKS_PER_BIT-1; a 3-bit index SHALL count the data bits.
REQ-014 IDLE->START SHALL occur when the FIFO is non-empty, popping one byte into the shift register on the same edge.
REQ-015 START->DATA and STOP transitions SHALL occur on counter wrap; DATA->STOP SHALL occur on counter wrap when index=7.
REQ-016 On STOP wrap, the FSM SHALL go to START with the next byte popped if the FIFO is non-empty (back-to-back, no idle gap), else to IDLE.
REQ-017 Latency: with the FIFO empty and the FSM in IDLE, a byte accepted on edge E SHALL cause tx=0 after edge E+2.
REQ-018 A simultaneous push and pop SHALL be legal when not full; the occupancy count SHALL remain unchanged.
REQ-019 The FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be held in a counter 0..FIFO_DEPTH; ready SHALL equal (count != FIFO_DEPTH).
REQ-020 data changing mid-frame SHALL NOT affect the frame in progress.
REQ-021 busy SHALL fall on the edge the FSM enters IDLE with count=0.

Reset
REQ-022 On reset, the following SHALL apply on the same edge:
- state=IDLE; tx=1; busy=0; ready=1.
- FIFO count and pointers=0; bit counter and index=0; shift register=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame, returning tx high after that edge; queued bytes SHALL be discarded.
REQ-024 reset SHALL take priority over send on the same edge.

Structure
REQ-025 Package uart_pkg SHALL hold:
- the state encodings IDLE=0, START=1, DATA=2, STOP=3;
- the frame constants DATA_BITS=8 and CLKS_PER_BIT default 16, shared with the existing receiver.
REQ-026 The buffer SHALL be a sub-module uart_tx_fifo (clk, reset, push, din, pop, dout, full, empty); the FSM and shifter SHALL live in uart_tx.

Verification
REQ-027 Single byte: reset, then send 0xA5 for one cycle with line idle -> tx=0 after edge E+2, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, stop=1, busy low 160 cycles after the start bit.
REQ-028 Back-to-back: push 0x00, 0xFF, 0x55 consecutively -> three frames, each 160 cycles, with no idle cycle between stop and the next start.
REQ-029 Full: push 5 bytes without gaps while the first byte is transmitting -> ready=0 once 4 bytes are queued, the 5th byte is dropped, and exactly 5-1+... are sent: the bytes accepted (first popped + 4 queued) are transmitted in order.
REQ-030 Reset mid-frame: assert reset 40 cycles into 0x3C -> tx=1 the following cycle, busy=0, ready=1, and no further frame is sent.
REQ-031 Loopback: connect tx to the existing receiver rx, send 0x00..0xFF -> the receiver data matches each byte with a ready pulse per frame.
